// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : pc_gen_pkg
// Brief  : Shared constants and state encoding for the fetch-stage program
//          counter generator (pc_gen).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   CHIP_ENABLE / CHIP_DISABLE  instruction-memory chip-enable levels
//   STOP / NO_STOP              stall-vector bit levels
//   RST_ENABLE                  asserted level of the active-low reset
//   PC_INCREMENT                sequential fetch stride in bytes
//   pc_state_e                  FSM encoding; bit 1 = ce, bit 0 = pending
//   The instruction address bus is [ADDR_W-1:0], sized by the pc_gen
//   parameter rather than a fixed package constant.
// ============================================================================
package pc_gen_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic RST_ENABLE   = 1'b0;
  localparam int   PC_INCREMENT = 4;

  // Encoding chosen so ce and redirect_pending are direct register bits:
  // state[1] is the chip enable, state[0] is the pending-branch flag.
  typedef enum logic [1:0] {
    ST_RESET    = 2'b00,
    ST_RUN      = 2'b10,
    ST_RUN_PEND = 2'b11
  } pc_state_e;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module : pc_gen
// Brief  : MIPS32 fetch-stage program counter. Advances by 4 per unstalled
//          cycle, takes flush and branch redirects, and buffers a branch that
//          arrives during a stall until the stall releases.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk                 in   1        rising-edge clock
//   rst                 in   1        asynchronous reset, active low
//   stall               in   STALL_W  stall vector, only bit 0 used here
//   flush               in   1        control redirect (exception / eret)
//   new_pc              in   ADDR_W   flush target
//   branch_flag         in   1        decode redirect request
//   branch_target_addr  in   ADDR_W   branch / jump target
//   pc                  out  ADDR_W   instruction fetch address
//   ce                  out  1        instruction-memory chip enable
//   redirect_pending    out  1        buffered branch awaiting stall release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  // Every loaded address is word aligned before it is stored.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_RESET;
      pc_q        <= RESET_VEC;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    unique case (state_q)
      // First edge out of reset only enables fetch; pc stays at RESET_VEC
      // and any redirect on this edge is ignored.
      ST_RESET: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_RUN_PEND: begin
        if (flush) begin
          pc_d    = align(new_pc);
          state_d = ST_RUN;
        end else if (stall[0] == STOP) begin
          // Hold pc; the newest branch seen during the stall wins.
          if (branch_flag) begin
            pend_addr_d = align(branch_target_addr);
            state_d     = ST_RUN_PEND;
          end
        end else if (branch_flag) begin
          pc_d    = align(branch_target_addr);
          state_d = ST_RUN;
        end else if (state_q == ST_RUN_PEND) begin
          pc_d    = pend_addr_q;
          state_d = ST_RUN;
        end else begin
          pc_d = pc_q + ADDR_W'(PC_INCREMENT);
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign pc               = pc_q;
  assign ce               = state_q[1];
  assign redirect_pending = state_q[0];

endmodule : pc_gen
`default_nettype wire
